// File: rtl/booth_job_sequencer_if.sv
// Bundle of the three handshakes around booth_job_sequencer:
//   upstream operand stream  : In_Valid/In_Ready/In_M/In_N
//   Booth multiplier control : Mul_M/Mul_N/Mul_Start/Mul_Reset/Mul_Product/Mul_Ready
//   downstream result stream : Out_Valid/Out_Ready/Out_Product/Out_Err (+Out_Mismatch)
//   status                   : Busy
// slave  = the sequencer's view, master = the surrounding environment's view.
// Optional macro BOOTH_SEQ_CHECK_EN adds the Out_Mismatch signal.
interface booth_job_sequencer_if;
  logic        In_Valid;
  logic        In_Ready;
  logic [7:0]  In_M;
  logic [7:0]  In_N;
  logic [7:0]  Mul_M;
  logic [7:0]  Mul_N;
  logic        Mul_Start;
  logic        Mul_Reset;
  logic [16:0] Mul_Product;
  logic        Mul_Ready;
  logic        Out_Valid;
  logic        Out_Ready;
  logic [15:0] Out_Product;
  logic        Out_Err;
  logic        Busy;
`ifdef BOOTH_SEQ_CHECK_EN
  logic        Out_Mismatch;
`endif

  modport slave (
`ifdef BOOTH_SEQ_CHECK_EN
    output Out_Mismatch,
`endif
    input  In_Valid, In_M, In_N, Mul_Product, Mul_Ready, Out_Ready,
    output In_Ready, Mul_M, Mul_N, Mul_Start, Mul_Reset, Out_Valid, Out_Product, Out_Err, Busy
  );

  modport master (
`ifdef BOOTH_SEQ_CHECK_EN
    input  Out_Mismatch,
`endif
    output In_Valid, In_M, In_N, Mul_Product, Mul_Ready, Out_Ready,
    input  In_Ready, Mul_M, Mul_N, Mul_Start, Mul_Reset, Out_Valid, Out_Product, Out_Err, Busy
  );
endinterface

// File: rtl/booth_job_sequencer.sv
// Operand scheduler in front of a sequential Booth multiplier. Buffers signed 8-bit operand
// pairs in a FIFO, runs each through the multiplier's Reset/Start/Ready protocol with a
// per-job timeout, and presents the 16-bit product on a valid/ready output.
// Ports:
//   clk   - clock, all logic on posedge
//   Reset - synchronous active-high reset
//   bus   - booth_job_sequencer_if.slave (operand in, multiplier control, result out, Busy)
// Optional macro BOOTH_SEQ_CHECK_EN: adds Out_Mismatch, set when a non-timeout result differs
// from the true signed product of the issued operands.
module booth_job_sequencer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CLR_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 255
) (
  input logic                  clk,
  input logic                  Reset,
  booth_job_sequencer_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam int unsigned ClrW = $clog2(CLR_CYCLES + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StClear = 2'd1;
  localparam logic [1:0] StRun   = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  // FIFO storage, entry = {M, N}
  logic [15:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;

  logic [1:0]      state_q, state_d;
  logic [ClrW-1:0] clr_cnt_q, clr_cnt_d;
  logic [7:0]      to_cnt_q, to_cnt_d;

  logic [7:0]      mul_m_q, mul_m_d, mul_n_q, mul_n_d;
  logic            mul_start_q, mul_reset_q;
  logic            out_valid_q, out_valid_d;
  logic [15:0]     out_product_q, out_product_d;
  logic            out_err_q, out_err_d;
  logic            busy_q;

  logic full, empty, push, pop;

  // Bit 16 only duplicates the sign; the result is taken from [15:0].
  logic unused_prod_sign;
  assign unused_prod_sign = bus.Mul_Product[16];

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  // No bypass: a pop in the same cycle does not open a slot while full.
  assign bus.In_Ready = !full && !Reset;
  assign push  = bus.In_Valid && bus.In_Ready;
  assign pop   = (state_q == StIdle) && !empty;
  assign count_d = count_q + CntW'(push) - CntW'(pop);

`ifdef BOOTH_SEQ_CHECK_EN
  logic               mismatch_q, mismatch_d;
  logic signed [15:0] m_ext, n_ext, ref_prod;
  assign m_ext    = 16'($signed(mul_m_q));
  assign n_ext    = 16'($signed(mul_n_q));
  assign ref_prod = m_ext * n_ext;
  assign bus.Out_Mismatch = mismatch_q;
`endif

  always_comb begin
    state_d       = state_q;
    clr_cnt_d     = clr_cnt_q;
    to_cnt_d      = to_cnt_q;
    mul_m_d       = mul_m_q;
    mul_n_d       = mul_n_q;
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
    out_err_d     = out_err_q;
`ifdef BOOTH_SEQ_CHECK_EN
    mismatch_d    = mismatch_q;
`endif
    case (state_q)
      StIdle: begin
        if (!empty) begin
          {mul_m_d, mul_n_d} = mem_q[rd_ptr_q];
          clr_cnt_d          = ClrW'(CLR_CYCLES);
          state_d            = StClear;
        end
      end
      StClear: begin
        // Counter parks at 0 while a stale Ready is still high.
        if (clr_cnt_q <= ClrW'(1)) begin
          clr_cnt_d = '0;
          if (!bus.Mul_Ready) begin
            to_cnt_d = '0;
            state_d  = StRun;
          end
        end else begin
          clr_cnt_d = clr_cnt_q - ClrW'(1);
        end
      end
      StRun: begin
        to_cnt_d = to_cnt_q + 8'd1;
        if (bus.Mul_Ready) begin
          out_product_d = bus.Mul_Product[15:0];
          out_err_d     = 1'b0;
          out_valid_d   = 1'b1;
`ifdef BOOTH_SEQ_CHECK_EN
          mismatch_d    = (bus.Mul_Product[15:0] != ref_prod);
`endif
          state_d       = StDone;
        end else if (to_cnt_d == 8'(TIMEOUT)) begin
          out_product_d = '0;
          out_err_d     = 1'b1;
          out_valid_d   = 1'b1;
`ifdef BOOTH_SEQ_CHECK_EN
          mismatch_d    = 1'b0;
`endif
          state_d       = StDone;
        end
      end
      default: begin
        if (bus.Out_Ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {bus.In_M, bus.In_N};
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= StIdle;
      clr_cnt_q     <= '0;
      to_cnt_q      <= '0;
      mul_m_q       <= '0;
      mul_n_q       <= '0;
      mul_start_q   <= 1'b0;
      mul_reset_q   <= 1'b1;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      out_err_q     <= 1'b0;
      busy_q        <= 1'b0;
`ifdef BOOTH_SEQ_CHECK_EN
      mismatch_q    <= 1'b0;
`endif
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q       <= count_d;
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      to_cnt_q      <= to_cnt_d;
      mul_m_q       <= mul_m_d;
      mul_n_q       <= mul_n_d;
      // Multiplier is held in reset everywhere except RUN.
      mul_start_q   <= (state_d == StRun);
      mul_reset_q   <= (state_d != StRun);
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      out_err_q     <= out_err_d;
      busy_q        <= (state_d != StIdle) || (count_d != '0);
`ifdef BOOTH_SEQ_CHECK_EN
      mismatch_q    <= mismatch_d;
`endif
    end
  end

  assign bus.Mul_M       = mul_m_q;
  assign bus.Mul_N       = mul_n_q;
  assign bus.Mul_Start   = mul_start_q;
  assign bus.Mul_Reset   = mul_reset_q;
  assign bus.Out_Valid   = out_valid_q;
  assign bus.Out_Product = out_product_q;
  assign bus.Out_Err     = out_err_q;
  assign bus.Busy        = busy_q;

endmodule

// File: tb/tb_booth_job_sequencer.sv
// Bench for booth_job_sequencer: behavioural Booth multiplier stand-in plus a queue-based
// reference of issued jobs, directed steps followed by a randomized traffic phase.
module tb_booth_job_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  booth_job_sequencer_if bus ();

  booth_job_sequencer #(
    .DEPTH     (4),
    .CLR_CYCLES(4),
    .TIMEOUT   (255)
  ) dut (
    .clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  // Multiplier stand-in: Ready rises after m_lat Start-high cycles, holds until reset.
  int          lat_min = 20;
  int          lat_max = 20;
  bit          hang    = 1'b0;
  bit          corrupt = 1'b0;
  logic        m_rdy   = 1'b0;
  logic [16:0] m_prod  = '0;
  int          m_cnt   = 0;
  int          m_lat   = 20;

  function automatic logic [16:0] mul17(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[16:0];
  endfunction

  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  always @(posedge clk) begin
    if (bus.Mul_Reset) begin
      m_rdy <= 1'b0;
      m_cnt <= 0;
      m_lat <= int'($urandom_range(lat_max, lat_min));
    end else if (bus.Mul_Start && !m_rdy) begin
      m_cnt <= m_cnt + 1;
      if (!hang && (m_cnt + 1 >= m_lat)) begin
        m_rdy  <= 1'b1;
        m_prod <= mul17(bus.Mul_M, bus.Mul_N) + 17'(corrupt);
      end
    end
  end

  assign bus.Mul_Ready   = m_rdy;
  assign bus.Mul_Product = m_prod;

  // Jobs accepted but not yet delivered, in push order.
  logic [7:0] q_m[$];
  logic [7:0] q_n[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_push(input logic [7:0] m, input logic [7:0] n, input bit track);
    bit acc;
    bus.In_Valid = 1'b1;
    bus.In_M     = m;
    bus.In_N     = n;
    acc = bus.In_Ready;
    tick();
    bus.In_Valid = 1'b0;
    if (acc && track) begin
      q_m.push_back(m);
      q_n.push_back(n);
    end
  endtask

  task automatic wait_valid(input int bound, output int cyc);
    cyc = 0;
    while (bus.Out_Valid !== 1'b1 && cyc < bound) begin
      tick();
      cyc++;
    end
    check("valid_within_bound", 32'(bus.Out_Valid), 1);
  endtask

  // Wait for the next result, compare with the queue head, then consume it.
  task automatic expect_next();
    int c;
    logic [7:0] m, n;
    wait_valid(600, c);
    if (q_m.size() == 0) begin
      check("result_expected", 0, 1);
    end else begin
      m = q_m.pop_front();
      n = q_n.pop_front();
      check("q_product", 32'(bus.Out_Product), 32'(ref_prod(m, n)));
      check("q_err", 32'(bus.Out_Err), 0);
      check("q_mul_m", 32'(bus.Mul_M), 32'(m));
    end
    bus.Out_Ready = 1'b1;
    tick();
  endtask

  initial begin
    int got;
    int c;
    int cyc;
    int pushed;
    bit acc;
    bit take;
    logic [15:0] held;

    bus.In_Valid  = 1'b0;
    bus.In_M      = '0;
    bus.In_N      = '0;
    bus.Out_Ready = 1'b0;

    // Reset held three cycles
    rst = 1'b1;
    repeat (3) tick();
    check("in_ready_in_reset", 32'(bus.In_Ready), 0);
    rst = 1'b0;
    tick();
    check("rst_in_ready", 32'(bus.In_Ready), 1);
    check("rst_mul_reset", 32'(bus.Mul_Reset), 1);
    check("rst_mul_start", 32'(bus.Mul_Start), 0);
    check("rst_out_valid", 32'(bus.Out_Valid), 0);
    check("rst_busy", 32'(bus.Busy), 0);
    check("rst_product", 32'(bus.Out_Product), 0);
    check("rst_err", 32'(bus.Out_Err), 0);
    check("rst_mul_m", 32'(bus.Mul_M), 0);

    // Single job latency: 100 x -99 with a 20-cycle multiplier
    lat_min = 20;
    lat_max = 20;
    bus.In_Valid = 1'b1;
    bus.In_M     = 8'h64;
    bus.In_N     = 8'h9D;
    got = -1;
    for (int k = 0; k < 400; k++) begin
      tick();
      bus.In_Valid = 1'b0;
      if (k == 1) begin
        check("clear_mul_reset", 32'(bus.Mul_Reset), 1);
        check("clear_mul_m", 32'(bus.Mul_M), 32'h64);
        check("clear_mul_n", 32'(bus.Mul_N), 32'h9D);
      end
      if (k == 4) check("clear_no_start", 32'(bus.Mul_Start), 0);
      if (k == 5) check("run_start", 32'(bus.Mul_Start), 1);
      if (bus.Out_Valid === 1'b1) begin
        got = k;
        break;
      end
    end
    check("latency", 32'(got), 26);
    check("lat_product", 32'(bus.Out_Product), 32'hD954);
    check("lat_err", 32'(bus.Out_Err), 0);

    // Stall in DONE while pushing five pairs: only four fit
    lat_min = 3;
    lat_max = 30;
    held = bus.Out_Product;
    for (int i = 0; i < 10; i++) begin
      if (i < 5) begin
        bus.In_Valid = 1'b1;
        bus.In_M = (i == 0) ? 8'h80 : (i == 1) ? 8'h7F : 8'($urandom);
        bus.In_N = (i == 0) ? 8'h80 : (i == 1) ? 8'hFF : 8'($urandom);
        acc = bus.In_Ready;
        check("fill_in_ready", 32'(acc), (i < 4) ? 1 : 0);
        if (acc) begin
          q_m.push_back(bus.In_M);
          q_n.push_back(bus.In_N);
        end
      end else begin
        bus.In_Valid = 1'b0;
      end
      tick();
      check("stall_valid", 32'(bus.Out_Valid), 1);
      check("stall_product", 32'(bus.Out_Product), 32'(held));
      check("stall_no_pop", 32'(bus.Mul_M), 32'h64);
    end
    bus.In_Valid = 1'b0;
    bus.Out_Ready = 1'b1;
    tick();
    check("first_pair_ref", 32'(ref_prod(8'h80, 8'h80)), 32'h4000);
    while (q_m.size() > 0) expect_next();

    // Timeout: the hung job errors out, the next one runs normally
    hang = 1'b1;
    do_push(8'h12, 8'h34, 1'b0);
    do_push(8'hE3, 8'h45, 1'b1);
    wait_valid(400, c);
    check("timeout_latency", 32'(c + 1), 260);
    check("timeout_err", 32'(bus.Out_Err), 1);
    check("timeout_product", 32'(bus.Out_Product), 0);
    hang = 1'b0;
    lat_min = 5;
    lat_max = 5;
    tick();
    expect_next();

    // Randomized traffic with random back-pressure
    lat_min = 1;
    lat_max = 12;
    pushed = 0;
    cyc = 0;
    while ((pushed < 12 || q_m.size() > 0) && cyc < 4000) begin
      bus.In_Valid  = (pushed < 12) && ($urandom_range(1, 0) == 1);
      bus.In_M      = 8'($urandom);
      bus.In_N      = 8'($urandom);
      bus.Out_Ready = ($urandom_range(1, 0) == 1);
      acc  = bus.In_Valid && bus.In_Ready;
      take = bus.Out_Valid && bus.Out_Ready;
      if (take) begin
        if (q_m.size() == 0) begin
          check("rand_spurious", 0, 1);
        end else begin
          check("rand_product", 32'(bus.Out_Product), 32'(ref_prod(q_m[0], q_n[0])));
          check("rand_err", 32'(bus.Out_Err), 0);
`ifdef BOOTH_SEQ_CHECK_EN
          check("rand_mismatch", 32'(bus.Out_Mismatch), 0);
`endif
          void'(q_m.pop_front());
          void'(q_n.pop_front());
        end
      end
      if (acc) begin
        q_m.push_back(bus.In_M);
        q_n.push_back(bus.In_N);
        pushed++;
      end
      tick();
      cyc++;
    end
    bus.In_Valid = 1'b0;
    bus.Out_Ready = 1'b1;
    check("rand_drained", 32'(q_m.size()), 0);
    tick();
    check("rand_idle_busy", 32'(bus.Busy), 0);

    // Reset mid-RUN with two jobs queued
    hang = 1'b1;
    q_m.delete();
    q_n.delete();
    do_push(8'h01, 8'h02, 1'b0);
    do_push(8'h03, 8'h04, 1'b0);
    do_push(8'h05, 8'h06, 1'b0);
    c = 0;
    while (bus.Mul_Start !== 1'b1 && c < 20) begin
      tick();
      c++;
    end
    check("reached_run", 32'(bus.Mul_Start), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(bus.In_Ready), 0);
    tick();
    check("mid_rst_out_valid", 32'(bus.Out_Valid), 0);
    check("mid_rst_mul_reset", 32'(bus.Mul_Reset), 1);
    check("mid_rst_mul_start", 32'(bus.Mul_Start), 0);
    check("mid_rst_busy", 32'(bus.Busy), 0);
    check("mid_rst_mul_m", 32'(bus.Mul_M), 0);
    rst = 1'b0;
    hang = 1'b0;
    lat_min = 5;
    lat_max = 5;
    tick();
    check("post_rst_in_ready", 32'(bus.In_Ready), 1);
    check("post_rst_busy", 32'(bus.Busy), 0);
    do_push(8'h03, 8'hF9, 1'b1);
    expect_next();
    repeat (3) tick();
    check("flushed_busy", 32'(bus.Busy), 0);
    check("flushed_valid", 32'(bus.Out_Valid), 0);

`ifdef BOOTH_SEQ_CHECK_EN
    // Checker: corrupted product flagged, correct one not
    corrupt = 1'b1;
    bus.Out_Ready = 1'b0;
    do_push(8'h64, 8'h9D, 1'b0);
    wait_valid(200, c);
    check("chk_bad_product", 32'(bus.Out_Product), 32'hD955);
    check("chk_bad_flag", 32'(bus.Out_Mismatch), 1);
    bus.Out_Ready = 1'b1;
    tick();
    corrupt = 1'b0;
    do_push(8'h64, 8'h9D, 1'b0);
    wait_valid(200, c);
    check("chk_good_product", 32'(bus.Out_Product), 32'hD954);
    check("chk_good_flag", 32'(bus.Out_Mismatch), 0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
